// File: rtl/traffic_phase_controller_pkg.sv
// Shared phase encodings and lamp codes for the signal-head controller,
// its lamp driver and any monitor that decodes the phase bus.
package traffic_phase_controller_pkg;

    typedef enum logic [1:0] {
        PH_RED    = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_FLASH  = 2'd3
    } phase_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b001;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    // Night flash alternates yellow and dark; the other phases are steady.
    function automatic logic [2:0] lamp_of(phase_t ph, logic flash_on);
        logic [2:0] l;
        l = LAMP_RED;
        unique case (ph)
            PH_RED:    l = LAMP_RED;
            PH_GREEN:  l = LAMP_GREEN;
            PH_YELLOW: l = LAMP_YELLOW;
            PH_FLASH:  l = flash_on ? LAMP_YELLOW : LAMP_OFF;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_phase_controller_phase_timer.sv
// Dwell counter: advances on tick, wraps to zero at the selected terminal
// count or when the owner requests an early cut.
module phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             cut,
    input  logic [CNT_W-1:0] last,
    output logic [CNT_W-1:0] count,
    output logic             at_end
);

    assign at_end = (count == last);

    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (tick)
            count <= (at_end || cut) ? '0 : count + CNT_W'(1);
    end

endmodule

// File: rtl/traffic_phase_controller.sv
// RED -> GREEN -> YELLOW sequencer with pedestrian cut/WALK grant and a
// night-mode flashing-yellow park state.
module traffic_phase_controller
    import traffic_phase_controller_pkg::*;
#(
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 2,
    parameter int RED_TICKS    = 6,
    parameter int MIN_GREEN    = 3,
    parameter int FLASH_TICKS  = 2,
    parameter int CNT_W        = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       night_mode,
    output logic [2:0] light,
    output logic [1:0] phase,
    output logic       walk,
    output logic       ped_ack
);

    phase_t           state;
    logic             ped_pending;
    logic             flash_on;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] last;
    logic             at_end;
    logic             cut;

    always_comb begin
        last = CNT_W'(RED_TICKS - 1);
        unique case (state)
            PH_RED:    last = CNT_W'(RED_TICKS - 1);
            PH_GREEN:  last = CNT_W'(GREEN_TICKS - 1);
            PH_YELLOW: last = CNT_W'(YELLOW_TICKS - 1);
            PH_FLASH:  last = CNT_W'(FLASH_TICKS - 1);
        endcase
    end

    // A pending request may end GREEN early once the minimum has been served.
    assign cut = (state == PH_GREEN) && ped_pending && (count >= CNT_W'(MIN_GREEN - 1));

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .tick   (tick),
        .cut    (cut),
        .last   (last),
        .count  (count),
        .at_end (at_end)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= PH_RED;
            ped_pending <= 1'b0;
            walk        <= 1'b0;
            ped_ack     <= 1'b0;
            flash_on    <= 1'b0;
        end else begin
            ped_ack <= 1'b0;
            if (tick) begin
                unique case (state)
                    PH_RED: if (at_end) begin
                        walk <= 1'b0;
                        if (night_mode) begin
                            state    <= PH_FLASH;
                            flash_on <= 1'b1;
                        end else begin
                            state <= PH_GREEN;
                        end
                    end
                    PH_GREEN: if (at_end || cut) state <= PH_YELLOW;
                    PH_YELLOW: if (at_end) begin
                        state <= PH_RED;
                        walk  <= ped_pending;
                        if (ped_pending) begin
                            ped_ack     <= 1'b1;
                            ped_pending <= 1'b0;
                        end
                    end
                    PH_FLASH: if (at_end) begin
                        flash_on <= ~flash_on;
                        if (!night_mode) state <= PH_RED;
                    end
                endcase
            end
            // Placed last so a request coinciding with the grant stays pending.
            if (ped_req) ped_pending <= 1'b1;
        end
    end

    assign light = lamp_of(state, flash_on);
    assign phase = state;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed + random stimulus against a tick-counting reference model of the
// signal head; every cycle's outputs are compared to the model.
module tb_traffic_phase_controller;

    localparam int GREEN  = 8;
    localparam int YELLOW = 2;
    localparam int RED    = 6;
    localparam int MING   = 3;
    localparam int FLASH  = 2;

    logic       clock = 1'b0;
    logic       reset, tick, ped_req, night_mode;
    logic [2:0] light;
    logic [1:0] phase;
    logic       walk, ped_ack;

    int errors = 0;
    int checks = 0;

    // model: phase index (0 red,1 green,2 yellow,3 flash) and ticks spent in it
    int m_ph, m_el;
    bit m_pend, m_walk, m_ack, m_flash;

    traffic_phase_controller dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .ped_req    (ped_req),
        .night_mode (night_mode),
        .light      (light),
        .phase      (phase),
        .walk       (walk),
        .ped_ack    (ped_ack)
    );

    always #5 clock = ~clock;

    function automatic void model_step(bit rst, bit tk, bit pr, bit nm);
        bit pend_now;
        if (rst) begin
            m_ph = 0; m_el = 0; m_pend = 0; m_walk = 0; m_ack = 0; m_flash = 0;
            return;
        end
        pend_now = m_pend;
        m_ack = 0;
        if (tk) begin
            m_el++;
            case (m_ph)
                0: if (m_el == RED) begin
                    m_el = 0; m_walk = 0;
                    if (nm) begin m_ph = 3; m_flash = 1; end
                    else m_ph = 1;
                end
                1: if (m_el == GREEN || (pend_now && m_el >= MING)) begin
                    m_ph = 2; m_el = 0;
                end
                2: if (m_el == YELLOW) begin
                    m_ph = 0; m_el = 0;
                    m_walk = pend_now;
                    if (pend_now) begin m_ack = 1; m_pend = 0; end
                end
                default: if (m_el == FLASH) begin
                    m_el = 0; m_flash = !m_flash;
                    if (!nm) m_ph = 0;
                end
            endcase
        end
        if (pr) m_pend = 1;
    endfunction

    function automatic logic [2:0] exp_light();
        case (m_ph)
            0: return 3'b100;
            1: return 3'b010;
            2: return 3'b001;
            default: return m_flash ? 3'b001 : 3'b000;
        endcase
    endfunction

    task automatic compare(string tag);
        logic [2:0] el;
        logic [1:0] ep;
        el = exp_light();
        ep = 2'(m_ph);
        checks++;
        assert (light === el) else begin
            errors++;
            $error("FAIL %s light: got %b expected %b", tag, light, el);
        end
        checks++;
        assert (phase === ep) else begin
            errors++;
            $error("FAIL %s phase: got %0d expected %0d", tag, phase, ep);
        end
        checks++;
        assert (walk === m_walk) else begin
            errors++;
            $error("FAIL %s walk: got %b expected %b", tag, walk, m_walk);
        end
        checks++;
        assert (ped_ack === m_ack) else begin
            errors++;
            $error("FAIL %s ped_ack: got %b expected %b", tag, ped_ack, m_ack);
        end
    endtask

    task automatic step(string tag, bit rst, bit tk, bit pr, bit nm);
        reset = rst; tick = tk; ped_req = pr; night_mode = nm;
        @(posedge clock);
        model_step(rst, tk, pr, nm);
        #1;
        compare(tag);
    endtask

    // Tick until the model reaches the given phase/elapsed point, bounded.
    task automatic run_until(string tag, int ph, int el, bit nm);
        bit hit;
        hit = 0;
        for (int i = 0; i < 60; i++) begin
            if (m_ph == ph && m_el == el) begin hit = 1; break; end
            step(tag, 0, 1, 0, nm);
        end
        checks++;
        assert (hit) else begin
            errors++;
            $error("FAIL %s reach: got phase %0d expected phase %0d el %0d", tag, m_ph, ph, el);
        end
    endtask

    initial begin
        reset = 1; tick = 0; ped_req = 0; night_mode = 0;
        m_ph = 0; m_el = 0; m_pend = 0; m_walk = 0; m_ack = 0; m_flash = 0;
        step("reset", 1, 0, 0, 0);
        step("reset", 1, 1, 1, 1);

        // free-running normal cycle
        for (int i = 0; i < 40; i++) step("free", 0, 1, 0, 0);

        // short pulse at GREEN start: minimum green, then WALK
        run_until("ped0", 1, 0, 0);
        step("ped0", 0, 1, 1, 0);
        for (int i = 0; i < 20; i++) step("ped0", 0, 1, 0, 0);

        // late request, then held across the grant
        run_until("ped5", 1, 5, 0);
        for (int i = 0; i < 30; i++) step("pedhold", 0, 1, 1, 0);
        for (int i = 0; i < 30; i++) step("pedhold", 0, 1, 0, 0);

        // night mode raised mid-GREEN, later dropped
        run_until("night", 1, 3, 0);
        for (int i = 0; i < 40; i++) step("night", 0, 1, i == 20, 1);
        for (int i = 0; i < 30; i++) step("day", 0, 1, 0, 0);

        // sparse ticks: every third cycle
        for (int i = 0; i < 120; i++) step("tick3", 0, (i % 3) == 0, 0, 0);

        // reset mid-YELLOW with a pending request
        run_until("rstY", 1, 0, 0);
        step("rstY", 0, 1, 1, 0);
        run_until("rstY", 2, 1, 0);
        step("rstY", 1, 1, 0, 0);
        for (int i = 0; i < 25; i++) step("rstY", 0, 1, 0, 0);

        // randomized soak
        begin
            bit nm;
            nm = 0;
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(39) == 0) nm = !nm;
                step("rand", $urandom_range(99) == 0, $urandom_range(1) == 1,
                     $urandom_range(9) == 0, nm);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
